// File: rtl/tlc_pkg.sv
// Shared junction-controller definitions: phase encodings and the lamp decode
// used by the scheduler and by the existing controller's benches.
package tlc_pkg;

    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] SIDE_G = 3'd2;
    localparam logic [2:0] SIDE_Y = 3'd3;
    localparam logic [2:0] WALK_R = 3'd4;

    typedef struct packed {
        logic mr;
        logic mg;
        logic my;
        logic sr;
        logic sg;
        logic sy;
        logic walk;
    } lamps_t;

    // Unknown codes fall back to all-red so a corrupted state can never show green.
    function automatic lamps_t lamp_decode(logic [2:0] ph);
        lamps_t l;
        l = '0;
        case (ph)
            MAIN_G: begin l.mg = 1'b1; l.sr = 1'b1; end
            MAIN_Y: begin l.my = 1'b1; l.sr = 1'b1; end
            SIDE_G: begin l.sg = 1'b1; l.mr = 1'b1; end
            SIDE_Y: begin l.sy = 1'b1; l.mr = 1'b1; end
            WALK_R: begin l.mr = 1'b1; l.sr = 1'b1; l.walk = 1'b1; end
            default: begin l.mr = 1'b1; l.sr = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_ped_phase_scheduler_if.sv
// Sensor/button inputs and lamp-driver outputs of the pedestrian phase scheduler.
interface tlc_ped_phase_scheduler_if;
    import tlc_pkg::*;

    logic       side_req;
    logic       ped_req;
    logic       MR, MG, MY;
    logic       SR, SG, SY;
    logic       WALK;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output side_req, ped_req,
        input  MR, MG, MY, SR, SG, SY, WALK, ped_ack, phase
    );

    modport slave (
        input  side_req, ped_req,
        output MR, MG, MY, SR, SG, SY, WALK, ped_ack, phase
    );

endinterface

// File: rtl/tlc_phase_timer.sv
// Loadable phase down-counter; holds at zero and flags expiry while zero.
module tlc_phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          sync_reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          exp
);

    logic [CW-1:0] cnt;

    // load wins over reset so the owner can preset the first phase duration.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (sync_reset) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign exp = (cnt == '0);

endmodule

// File: rtl/tlc_ped_phase_scheduler.sv
// Junction phase scheduler: main/side lights with an on-demand all-red pedestrian
// phase; main street rests in green when there is no demand.
module tlc_ped_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int CW     = 4,
    parameter int T_MG   = 8,
    parameter int T_MY   = 2,
    parameter int T_SG   = 5,
    parameter int T_SY   = 2,
    parameter int T_WALK = 4
) (
    input  logic                         clk,
    input  logic                         sync_reset,
    tlc_ped_phase_scheduler_if.slave     bus
);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic          exp;
    logic          load;
    logic          enter_walk;
    logic [CW-1:0] load_val;
    logic          ped_pend;
    logic          ped_ack_r;
    lamps_t        lamps;

    function automatic logic [CW-1:0] dur_m1(logic [2:0] s);
        case (s)
            MAIN_G:  return CW'(T_MG - 1);
            MAIN_Y:  return CW'(T_MY - 1);
            SIDE_G:  return CW'(T_SG - 1);
            SIDE_Y:  return CW'(T_SY - 1);
            WALK_R:  return CW'(T_WALK - 1);
            default: return CW'(T_MG - 1);
        endcase
    endfunction

    // Pedestrians beat side traffic at MAIN_Y expiry; side is picked up after WALK_R.
    always_comb begin
        nxt = state;
        if (exp) begin
            case (state)
                MAIN_G:  nxt = (bus.side_req || ped_pend) ? MAIN_Y : MAIN_G;
                MAIN_Y:  nxt = ped_pend ? WALK_R : SIDE_G;
                SIDE_G:  nxt = SIDE_Y;
                SIDE_Y:  nxt = MAIN_G;
                WALK_R:  nxt = bus.side_req ? SIDE_G : MAIN_G;
                default: nxt = MAIN_G;
            endcase
        end
    end

    assign enter_walk = (nxt == WALK_R) && (state != WALK_R);
    assign load       = sync_reset || (nxt != state);
    assign load_val   = sync_reset ? dur_m1(MAIN_G) : dur_m1(nxt);

    tlc_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk        (clk),
        .sync_reset (sync_reset),
        .load       (load),
        .load_val   (load_val),
        .exp        (exp)
    );

    // A request arriving on the cycle WALK_R is entered is absorbed by that walk.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state     <= MAIN_G;
            ped_pend  <= 1'b0;
            ped_ack_r <= 1'b0;
        end else begin
            state     <= nxt;
            ped_ack_r <= enter_walk;
            if (enter_walk) begin
                ped_pend <= 1'b0;
            end else if (bus.ped_req && (state != WALK_R)) begin
                ped_pend <= 1'b1;
            end
        end
    end

    assign lamps       = lamp_decode(state);
    assign bus.MR      = lamps.mr;
    assign bus.MG      = lamps.mg;
    assign bus.MY      = lamps.my;
    assign bus.SR      = lamps.sr;
    assign bus.SG      = lamps.sg;
    assign bus.SY      = lamps.sy;
    assign bus.WALK    = lamps.walk;
    assign bus.ped_ack = ped_ack_r;
    assign bus.phase   = state;

endmodule

// File: tb/tb_tlc_ped_phase_scheduler.sv
// Scoreboard bench for tlc_ped_phase_scheduler: directed scenarios then random traffic,
// predicted by a phase/age model and compared cycle by cycle.
module tb_tlc_ped_phase_scheduler;

    localparam int CW     = 4;
    localparam int T_MG   = 8;
    localparam int T_MY   = 2;
    localparam int T_SG   = 5;
    localparam int T_SY   = 2;
    localparam int T_WALK = 4;

    typedef struct packed {
        logic [6:0] lamps;
        logic       ack;
        logic [2:0] ph;
    } exp_t;

    logic clk;
    logic sync_reset;
    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;

    int   m_ph;
    int   m_age;
    bit   m_pend;
    bit   m_ack;

    tlc_ped_phase_scheduler_if bus_if ();

    tlc_ped_phase_scheduler #(
        .CW     (CW),
        .T_MG   (T_MG),
        .T_MY   (T_MY),
        .T_SG   (T_SG),
        .T_SY   (T_SY),
        .T_WALK (T_WALK)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic int dur(int ph);
        case (ph)
            0: return T_MG;
            1: return T_MY;
            2: return T_SG;
            3: return T_SY;
            default: return T_WALK;
        endcase
    endfunction

    // {MR,MG,MY,SR,SG,SY,WALK}
    function automatic logic [6:0] exp_lamps(int ph);
        case (ph)
            0: return 7'b0101000;
            1: return 7'b0011000;
            2: return 7'b1000100;
            3: return 7'b1000010;
            default: return 7'b1001001;
        endcase
    endfunction

    // Phase model: tracks how long the current phase has been shown and applies
    // the junction rules; the result is what must be visible after the next edge.
    task automatic model_step(input bit r, input bit s, input bit p);
        int nph;
        exp_t e;
        if (r) begin
            m_ph = 0; m_age = 0; m_pend = 0; m_ack = 0;
        end else begin
            nph = m_ph;
            if (m_age + 1 >= dur(m_ph)) begin
                case (m_ph)
                    0: if (s || m_pend) nph = 1;
                    1: nph = m_pend ? 4 : 2;
                    2: nph = 3;
                    3: nph = 0;
                    default: nph = s ? 2 : 0;
                endcase
            end
            m_ack = (nph == 4) && (m_ph != 4);
            if (m_ack) m_pend = 0;
            else if (p && m_ph != 4) m_pend = 1;
            m_age = (nph != m_ph) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
            m_ph  = nph;
        end
        e.lamps = exp_lamps(m_ph);
        e.ack   = m_ack;
        e.ph    = 3'(m_ph);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit p);
        @(negedge clk);
        sync_reset      = r;
        bus_if.side_req = s;
        bus_if.ped_req  = p;
        model_step(r, s, p);
    endtask

    // Monitor: one expected entry per edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("lamps", {25'd0, bus_if.MR, bus_if.MG, bus_if.MY, bus_if.SR,
                              bus_if.SG, bus_if.SY, bus_if.WALK}, {25'd0, e.lamps});
                chk("ped_ack", {31'd0, bus_if.ped_ack}, {31'd0, e.ack});
                chk("phase", {29'd0, bus_if.phase}, {29'd0, e.ph});
                chk("safety", {31'd0, ($countones({bus_if.MR, bus_if.MG, bus_if.MY}) == 1) &&
                                      ($countones({bus_if.SR, bus_if.SG, bus_if.SY}) == 1) &&
                                      (bus_if.MR || bus_if.SR)}, 32'd1);
            end
        end
    end

    initial begin
        bit side;
        int sg;
        bit done;
        n_checks = 0;
        n_pass   = 0;
        sync_reset      = 1'b1;
        bus_if.side_req = 1'b0;
        bus_if.ped_req  = 1'b0;

        // Reset, then idle: main green rests.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0);

        // Continuous side demand.
        cyc(1, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0);

        // Pedestrian pulse in cycle 3 of main green.
        cyc(1, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, i == 3);

        // Side demand plus pedestrian pulse: walk first, then side.
        cyc(1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, i == 2);

        // Requests during WALK_R (ignored) and SIDE_G (served later).
        cyc(1, 0, 0);
        for (int i = 0; i < 70; i++)
            cyc(0, i < 20, (i == 1) || (m_ph == 4) || (m_ph == 2 && i >= 14));

        // Reset in cycle 2 of side green, then a full main green.
        cyc(1, 0, 0);
        sg = 0;
        done = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_ph == 2 && !done) sg++;
            if (!done && sg == 3) begin
                done = 1;
                cyc(1, 1, 0);
            end else begin
                cyc(0, !done, 0);
            end
        end

        // Random traffic with occasional mid-phase resets.
        cyc(1, 0, 0);
        side = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) side = !side;
            cyc($urandom_range(0, 299) == 0, side, $urandom_range(0, 15) == 0);
        end

        @(posedge clk);
        #3;
        chk("drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
